// File: rtl/car_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | car_pkg: car types, playfield borders and spawn FSM state encoding.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package car_pkg;

   localparam logic [1:0] YELLOWCAR = 2'd0;
   localparam logic [1:0] REDCAR    = 2'd1;
   localparam logic [1:0] BLUETRUCK = 2'd2;

   localparam int BORDER_L = 215;
   localparam int BORDER_R = 399;
   localparam int CAR_W    = 32;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WAIT_PERIOD = 3'd1,
      S_PICK        = 3'd2,
      S_ARM         = 3'd3,
      S_DONE        = 3'd4
   } spawn_state_e;

   function automatic logic [10:0] lane_x(input logic [2:0] lane, input int pitch);
      return 11'(BORDER_L + int'(lane) * pitch);
   endfunction

   // Two random bits give four codes; the unused fourth folds onto the truck.
   function automatic logic [1:0] rnd_type(input logic [1:0] bits);
      return (bits == 2'd3) ? BLUETRUCK : bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spawn_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), low bits out.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spawn_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       advance,
   output logic [4:0] rnd
);
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) lfsr_q <= SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign rnd = lfsr_q[4:0];

endmodule
`default_nettype wire

// File: rtl/car_spawn_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | car_spawn_dispatcher: round-robin enemy-car release, random lane and |
// | type. Define SPAWN_SPEEDUP_EN to shorten the period as spawns grow.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module car_spawn_dispatcher #(
   parameter int          NUM_SLOTS        = 4,
   parameter int          SPAWN_PERIOD_SEC = 2,
   parameter int          MIN_PERIOD_SEC   = 1,
   parameter int          SPEEDUP_SPAWNS   = 8,
   parameter int          NUM_LANES        = 5,
   parameter int          LANE_PITCH       = 38,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic                   onesec,
   input  logic                   enable,
   input  logic [NUM_SLOTS-1:0]   slot_ready,
   output logic [NUM_SLOTS-1:0]   releasecar,
   output logic [10:0]            carXinitial,
   output logic [NUM_SLOTS*2-1:0] cartype,
   output logic [7:0]             spawn_count
);
   import car_pkg::*;

   localparam int         SEL_W       = $clog2(NUM_SLOTS);
   localparam logic [7:0] PERIOD_INIT = 8'(SPAWN_PERIOD_SEC);

   if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || NUM_LANES < 1 || NUM_LANES > 8 ||
       SPAWN_PERIOD_SEC < 1 || MIN_PERIOD_SEC < 1 || SPEEDUP_SPAWNS < 1 || LFSR_SEED == 16'd0 ||
       BORDER_L + (NUM_LANES - 1) * LANE_PITCH > BORDER_R - CAR_W) begin : g_bad_config
      $error("car_spawn_dispatcher: invalid parameter set");
   end

   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int b);
      return SEL_W'((int'(a) + b) % NUM_SLOTS);
   endfunction

   spawn_state_e            state_q, state_d;
   logic [7:0]              sec_cnt_q, sec_cnt_d, spawn_count_q, spawn_count_d, period_w;
   logic [SEL_W-1:0]        sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick_idx;
   logic [2:0]              lane_q, lane_d, last_lane_q, last_lane_d, lane_raw, lane_pick;
   logic [NUM_SLOTS-1:0]    releasecar_q, releasecar_d;
   logic [10:0]             carx_q, carx_d;
   logic [NUM_SLOTS*2-1:0]  cartype_q, cartype_d;
   logic [4:0]              rnd;
   logic                    pick_hit;

`ifdef SPAWN_SPEEDUP_EN
   logic [7:0] period_q, period_d, step_cnt_q, step_cnt_d;
   assign period_w = period_q;
`else
   assign period_w = PERIOD_INIT;
`endif

   spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .resetN  (resetN),
      .advance (enable),
      .rnd     (rnd)
   );

   // Avoid repeating the previous lane so consecutive cars never stack.
   assign lane_raw  = 3'(int'(rnd[2:0]) % NUM_LANES);
   assign lane_pick = (lane_raw == last_lane_q) ? 3'((int'(lane_raw) + 1) % NUM_LANES) : lane_raw;

   // Descending scan so the last assignment wins: first ready slot from rr_ptr.
   always_comb begin
      pick_hit = 1'b0;
      pick_idx = rr_ptr_q;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (slot_ready[wrap_add(rr_ptr_q, k)]) begin
            pick_hit = 1'b1;
            pick_idx = wrap_add(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      sec_cnt_d     = sec_cnt_q;
      sel_d         = sel_q;
      rr_ptr_d      = rr_ptr_q;
      lane_d        = lane_q;
      last_lane_d   = last_lane_q;
      releasecar_d  = releasecar_q;
      carx_d        = carx_q;
      cartype_d     = cartype_q;
      spawn_count_d = spawn_count_q;
`ifdef SPAWN_SPEEDUP_EN
      period_d      = period_q;
      step_cnt_d    = step_cnt_q;
`endif
      if (!enable) begin
         state_d      = S_IDLE;
         releasecar_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d   = S_WAIT_PERIOD;
               sec_cnt_d = '0;
            end
            S_WAIT_PERIOD: begin
               if (onesec) begin
                  if (sec_cnt_q + 8'd1 >= period_w) state_d = S_PICK;
                  else                              sec_cnt_d = sec_cnt_q + 8'd1;
               end
            end
            S_PICK: begin
               if (pick_hit) begin
                  sel_d        = pick_idx;
                  lane_d       = lane_pick;
                  carx_d       = lane_x(lane_pick, LANE_PITCH);
                  cartype_d[int'(pick_idx)*2 +: 2] = rnd_type(rnd[4:3]);
                  releasecar_d = NUM_SLOTS'(1) << pick_idx;
                  state_d      = S_ARM;
               end
            end
            S_ARM: begin
               // A mover reclaimed by someone else cannot take the car: re-pick.
               if (!slot_ready[sel_q]) begin
                  releasecar_d = '0;
                  state_d      = S_PICK;
               end else if (startOfFrame) begin
                  releasecar_d = '0;
                  state_d      = S_DONE;
               end
            end
            S_DONE: begin
               rr_ptr_d    = wrap_add(sel_q, 1);
               last_lane_d = lane_q;
               if (spawn_count_q != 8'hFF) spawn_count_d = spawn_count_q + 8'd1;
`ifdef SPAWN_SPEEDUP_EN
               if (step_cnt_q + 8'd1 >= 8'(SPEEDUP_SPAWNS)) begin
                  step_cnt_d = '0;
                  if (period_q > 8'(MIN_PERIOD_SEC)) period_d = period_q - 8'd1;
               end else begin
                  step_cnt_d = step_cnt_q + 8'd1;
               end
`endif
               sec_cnt_d = '0;
               state_d   = S_WAIT_PERIOD;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= S_IDLE;
         sec_cnt_q     <= '0;
         sel_q         <= '0;
         rr_ptr_q      <= '0;
         lane_q        <= '0;
         last_lane_q   <= '0;
         releasecar_q  <= '0;
         carx_q        <= 11'(BORDER_L);
         cartype_q     <= {NUM_SLOTS{YELLOWCAR}};
         spawn_count_q <= '0;
`ifdef SPAWN_SPEEDUP_EN
         period_q      <= PERIOD_INIT;
         step_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         sec_cnt_q     <= sec_cnt_d;
         sel_q         <= sel_d;
         rr_ptr_q      <= rr_ptr_d;
         lane_q        <= lane_d;
         last_lane_q   <= last_lane_d;
         releasecar_q  <= releasecar_d;
         carx_q        <= carx_d;
         cartype_q     <= cartype_d;
         spawn_count_q <= spawn_count_d;
`ifdef SPAWN_SPEEDUP_EN
         period_q      <= period_d;
         step_cnt_q    <= step_cnt_d;
`endif
      end
   end

   assign releasecar  = releasecar_q;
   assign carXinitial = carx_q;
   assign cartype     = cartype_q;
   assign spawn_count = spawn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_car_spawn_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_car_spawn_dispatcher: directed + randomized spawn checks against  |
// | a behavioural model. Rev 1.0                                         |
// +----------------------------------------------------------------------+
module tb_car_spawn_dispatcher;
   localparam int NS     = 4;
`ifdef SPAWN_SPEEDUP_EN
   localparam int PERIOD = 3;
`else
   localparam int PERIOD = 2;
`endif
   localparam int          MINP  = 1;
   localparam int          STEPS = 8;
   localparam int          LANES = 5;
   localparam int          PITCH = 38;
   localparam int          XL    = 215;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic          clk = 1'b0;
   logic          resetN, startOfFrame, onesec, enable;
   logic [NS-1:0] slot_ready, releasecar;
   logic [10:0]   carXinitial;
   logic [2*NS-1:0] cartype;
   logic [7:0]    spawn_count;

   car_spawn_dispatcher #(
      .NUM_SLOTS(NS), .SPAWN_PERIOD_SEC(PERIOD), .MIN_PERIOD_SEC(MINP), .SPEEDUP_SPAWNS(STEPS),
      .NUM_LANES(LANES), .LANE_PITCH(PITCH), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .onesec(onesec), .enable(enable),
      .slot_ready(slot_ready), .releasecar(releasecar), .carXinitial(carXinitial),
      .cartype(cartype), .spawn_count(spawn_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [15:0] m_lfsr, m_lfsr_prev;
   int          m_rr, m_last_lane, m_count, m_slot, m_lane;
   logic [1:0]  m_type [NS];

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      logic fb;
      fb = ^(v & 16'hB400);
      return 16'((v << 1) | 16'(fb));
   endfunction

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_lfsr      <= SEED;
         m_lfsr_prev <= SEED;
      end else begin
         m_lfsr_prev <= m_lfsr;
         if (enable) m_lfsr <= lfsr_adv(m_lfsr);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_last_lane = 0; m_count = 0; m_slot = 0; m_lane = 0;
      for (int i = 0; i < NS; i++) m_type[i] = 2'd0;
   endtask

   function automatic int m_period();
`ifdef SPAWN_SPEEDUP_EN
      int p;
      p = PERIOD - m_count / STEPS;
      return (p < MINP) ? MINP : p;
`else
      return PERIOD;
`endif
   endfunction

   function automatic int m_pick(input logic [NS-1:0] rdy);
      for (int k = 0; k < NS; k++) if (rdy[(m_rr + k) % NS]) return (m_rr + k) % NS;
      return -1;
   endfunction

   function automatic logic [2*NS-1:0] m_types_packed();
      logic [2*NS-1:0] v;
      v = '0;
      for (int i = 0; i < NS; i++) v[2*i +: 2] = m_type[i];
      return v;
   endfunction

   // Called on the first sample where the DUT shows a release request.
   task automatic check_new_release(input string tag);
      int slot, lane, inset;
      slot = m_pick(slot_ready);
      if (slot < 0) slot = 0;
      lane = int'(m_lfsr_prev[2:0]) % LANES;
      if (lane == m_last_lane) lane = (lane + 1) % LANES;
      m_type[slot] = (m_lfsr_prev[4:3] == 2'd3) ? 2'd2 : m_lfsr_prev[4:3];
      m_slot = slot;
      m_lane = lane;
      inset = 0;
      for (int l = 0; l < LANES; l++) if (int'(carXinitial) == XL + l * PITCH) inset = 1;
      check({tag, " releasecar"}, 32'(releasecar), 32'(1) << slot);
      check({tag, " carX"}, 32'(carXinitial), 32'(XL + lane * PITCH));
      check({tag, " carX in lane set"}, 32'(inset), 32'd1);
      check({tag, " carX differs from last"}, 32'(int'(carXinitial) != XL + m_last_lane * PITCH), 32'd1);
      check({tag, " cartype"}, 32'(cartype), 32'(m_types_packed()));
   endtask

   task automatic wait_release(input string tag, input int budget);
      int n;
      n = 0;
      while (releasecar == '0 && n < budget) begin
         step();
         n++;
      end
      check({tag, " released"}, 32'(releasecar != '0), 32'd1);
      if (releasecar != '0) check_new_release(tag);
   endtask

   // Pulses onesec until a release appears; the pulse count is the period.
   task automatic run_period(input string tag);
      int pulses;
      bit seen;
      pulses = 0;
      seen = 1'b0;
      while (!seen && pulses < 10) begin
         onesec = 1'b1; step(); onesec = 1'b0;
         pulses++;
         startOfFrame = 1'($urandom_range(0, 1));
         step();
         startOfFrame = 1'b0;
         if (releasecar != '0) seen = 1'b1;
         else repeat ($urandom_range(0, 2)) step();
      end
      check({tag, " period"}, 32'(pulses), 32'(m_period()));
      check({tag, " released"}, 32'(seen), 32'd1);
      if (seen) check_new_release(tag);
   endtask

   task automatic complete(input string tag);
      repeat ($urandom_range(0, 3)) begin
         onesec = 1'($urandom_range(0, 1));
         step();
         onesec = 1'b0;
         check({tag, " hold"}, 32'(releasecar), 32'(1) << m_slot);
      end
      startOfFrame = 1'b1;
      onesec = 1'($urandom_range(0, 1));
      step();
      startOfFrame = 1'b0;
      onesec = 1'b0;
      check({tag, " done clears"}, 32'(releasecar), 32'd0);
      step();
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_rr = (m_slot + 1) % NS;
      m_last_lane = m_lane;
      check({tag, " spawn_count"}, 32'(spawn_count), 32'(m_count));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " releasecar"}, 32'(releasecar), 32'd0);
      check({tag, " cartype"}, 32'(cartype), 32'd0);
      check({tag, " carX"}, 32'(carXinitial), 32'(XL));
      check({tag, " spawn_count"}, 32'(spawn_count), 32'd0);
   endtask

   initial begin
      int nz;
      logic [NS-1:0] rdy;
      resetN = 1'b0; enable = 1'b0; onesec = 1'b0; startOfFrame = 1'b0; slot_ready = '1;
      model_reset();
      repeat (3) step();
      check_reset_outputs("reset");
      resetN = 1'b1;
      step();
      enable = 1'b1;
      repeat (2) step();

      // First spawn from slot 0, then seven more round-robin (rr back to 0)
      run_period("first");
      complete("first");
      for (int i = 0; i < 7; i++) begin
         run_period("rr");
         complete("rr");
      end

      // Sparse ready mask: slot 1 then slot 3
      slot_ready = 4'b1010;
      run_period("sparse_a");
      check("sparse_a slot1", 32'(releasecar), 32'd2);
      complete("sparse_a");
      run_period("sparse_b");
      check("sparse_b slot3", 32'(releasecar), 32'd8);
      complete("sparse_b");

      // Nobody ready: PICK waits without releasing
      slot_ready = '0;
      for (int p = 0; p < m_period(); p++) begin
         onesec = 1'b1; step(); onesec = 1'b0; step();
      end
      nz = 0;
      repeat (50) begin
         step();
         if (releasecar != '0) nz++;
      end
      check("no ready stays idle", 32'(nz), 32'd0);
      slot_ready = 4'($urandom_range(1, 15));
      wait_release("late ready", 3);
      complete("late ready");

      // Withdraw: selected slot drops ready while armed
      slot_ready = '1;
      run_period("withdraw");
      rdy = '1;
      rdy[m_slot] = 1'b0;
      slot_ready = rdy;
      step();
      check("withdraw clears", 32'(releasecar), 32'd0);
      check("withdraw no count", 32'(spawn_count), 32'(m_count));
      wait_release("repick", 4);
      complete("repick");
      slot_ready = '1;

      // Enable drop while armed
      run_period("abort");
      enable = 1'b0;
      step();
      check("abort releasecar", 32'(releasecar), 32'd0);
      check("abort cartype hold", 32'(cartype), 32'(m_types_packed()));
      check("abort carX hold", 32'(carXinitial), 32'(XL + m_lane * PITCH));
      check("abort count hold", 32'(spawn_count), 32'(m_count));
      repeat (3) step();
      enable = 1'b1;
      repeat (2) step();

      // Randomized ready masks
      for (int i = 0; i < 16; i++) begin
         slot_ready = 4'($urandom_range(1, 15));
         run_period("rand");
         complete("rand");
      end

      // Asynchronous reset while armed
      slot_ready = '1;
      run_period("pre-reset");
      resetN = 1'b0;
      #1;
      check_reset_outputs("async reset");
      model_reset();
      repeat (2) step();
      resetN = 1'b1;
      step();
      repeat (2) step();
      run_period("post-reset");
      check("post-reset slot0", 32'(releasecar), 32'd1);
      complete("post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
